// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for a whole cyc,
// with a per-access stall timeout that terminates hung accesses.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT      = 16,
  parameter logic [31:0] TIMEOUT_DATA = 32'hdead_beef
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o,
  input  logic        timeout_clr_i
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_grant, w_grant_nxt;
  logic       r_last, w_last_nxt;
  logic [7:0] r_cnt;
  logic       r_timeout;

  logic w_req0, w_req1, w_mcyc, w_mstb, w_to;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;
  assign w_mcyc = (r_grant[0] & m0_cyc_i) | (r_grant[1] & m1_cyc_i);
  assign w_mstb = (r_grant[0] & m0_stb_i) | (r_grant[1] & m1_stb_i);
  // A slave ack in the expiry cycle wins over the timeout.
  assign w_to   = w_mstb & ~s_ack_i & (r_cnt == LP_TIMEOUT);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = r_last ? 2'b01 : 2'b10;
        end else if (w_req0) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = 2'b01;
        end else if (w_req1) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = 2'b10;
        end
      end
      ST_BUSY: begin
        // Releasing always passes through IDLE, so no same-edge re-grant.
        if (!w_mcyc) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 2'b00;
          w_last_nxt  = r_grant[1];
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  always_comb begin
    s_cyc_o  = w_mcyc;
    s_stb_o  = w_mstb & ~w_to;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = 32'h0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m0_dat_o = 32'h0;
    m1_ack_o = 1'b0;
    m1_dat_o = 32'h0;
    if (r_grant[0]) begin
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = s_ack_i | w_to;
      m0_dat_o = w_to ? TIMEOUT_DATA : s_dat_i;
    end else if (r_grant[1]) begin
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      m1_ack_o = s_ack_i | w_to;
      m1_dat_o = w_to ? TIMEOUT_DATA : s_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || s_ack_i || !s_stb_o) r_cnt <= 8'd0;
      else                                           r_cnt <= r_cnt + 8'd1;
      if (w_to)               r_timeout <= 1'b1;
      else if (timeout_clr_i) r_timeout <= 1'b0;
    end
  end

  assign grant_o   = r_grant;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus randomized masters and slave,
// all checked each cycle against a transaction-level reference model.
module tb_wb_arbiter_2m;
  localparam int          TO  = 16;
  localparam logic [31:0] TOD = 32'hdead_beef;

  logic        clk = 1'b0, rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, timeout_o, timeout_clr_i;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [1:0]  grant_o;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.TIMEOUT(TO), .TIMEOUT_DATA(TOD)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
  );

  int n_chk = 0, n_pass = 0;
  // Reference model: owner 0 = nobody, 1 = master 0, 2 = master 1.
  int owner = 0, last_idx = 1, stall = 0;
  bit mdl_to = 1'b0;
  bit e_ack0 = 1'b0, e_ack1 = 1'b0;
  logic        obs_stb;
  logic [31:0] obs_dat0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic mdl_reset();
    owner = 0; last_idx = 1; stall = 0; mdl_to = 1'b0;
    e_ack0 = 1'b0; e_ack1 = 1'b0;
  endtask

  task automatic drive(input int m, input bit cyc, input bit stb, input bit we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  // One bus cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit          cyc_g, stb_g, we_g, to, ea0, ea1, req0, req1;
    logic [3:0]  sel_g;
    logic [31:0] adr_g, wd_g, ed0, ed1;
    cyc_g = 0; stb_g = 0; we_g = 0; sel_g = 0; adr_g = 0; wd_g = 0;
    to = 0; ea0 = 0; ea1 = 0; ed0 = 0; ed1 = 0;
    @(negedge clk);
    if (owner == 1) begin
      cyc_g = m0_cyc_i; stb_g = m0_stb_i; we_g = m0_we_i; sel_g = m0_sel_i; adr_g = m0_adr_i; wd_g = m0_dat_i;
    end else if (owner == 2) begin
      cyc_g = m1_cyc_i; stb_g = m1_stb_i; we_g = m1_we_i; sel_g = m1_sel_i; adr_g = m1_adr_i; wd_g = m1_dat_i;
    end
    if (owner != 0) begin
      to = stb_g && (stall == TO) && !s_ack_i;
      if (owner == 1) begin ea0 = s_ack_i | to; ed0 = to ? TOD : s_dat_i; end
      else            begin ea1 = s_ack_i | to; ed1 = to ? TOD : s_dat_i; end
    end
    check_eq("grant", 32'(grant_o), (owner == 0) ? 32'd0 : (owner == 1) ? 32'd1 : 32'd2);
    check_eq("s_cyc", 32'(s_cyc_o), 32'(cyc_g));
    check_eq("s_stb", 32'(s_stb_o), 32'(stb_g & ~to));
    check_eq("s_we", 32'(s_we_o), 32'(we_g));
    check_eq("s_sel", 32'(s_sel_o), 32'(sel_g));
    check_eq("s_adr", s_adr_o, adr_g);
    check_eq("s_dat", s_dat_o, wd_g);
    check_eq("m0_ack", 32'(m0_ack_o), 32'(ea0));
    check_eq("m0_dat", m0_dat_o, ed0);
    check_eq("m1_ack", 32'(m1_ack_o), 32'(ea1));
    check_eq("m1_dat", m1_dat_o, ed1);
    check_eq("timeout", 32'(timeout_o), 32'(mdl_to));
    obs_stb = s_stb_o; obs_dat0 = m0_dat_o;
    e_ack0 = ea0; e_ack1 = ea1;
    req0 = m0_cyc_i & m0_stb_i;
    req1 = m1_cyc_i & m1_stb_i;
    @(posedge clk);
    if (owner == 0) begin
      if (req0 && req1) owner = (last_idx == 1) ? 1 : 2;
      else if (req0)    owner = 1;
      else if (req1)    owner = 2;
      stall = 0;
    end else if (!cyc_g) begin
      last_idx = owner - 1;
      owner = 0;
      stall = 0;
    end else if (s_ack_i || !stb_g || to) stall = 0;
    else stall++;
    if (to) mdl_to = 1'b1;
    else if (timeout_clr_i) mdl_to = 1'b0;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    s_ack_i = 1'b0; s_dat_i = 32'h0; timeout_clr_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_reset();
  endtask

  task automatic rand_master(input int m, input bit acked);
    bit cyc, stb;
    cyc = (m == 0) ? m0_cyc_i : m1_cyc_i;
    stb = (m == 0) ? m0_stb_i : m1_stb_i;
    if (!cyc) begin
      if ($urandom_range(3) == 0)
        drive(m, 1, 1, 1'($urandom_range(1)), 4'($urandom), $urandom, $urandom);
    end else if (!(stb && !acked)) begin
      case ($urandom_range(3))
        0:       drive(m, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        1:       drive(m, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        default: drive(m, 1, 1, 1'($urandom_range(1)), 4'($urandom), $urandom, $urandom);
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  stalls;
    bit  hung;
    // Reset values, including while reset is held.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    s_ack_i = 1'b0; s_dat_i = 32'h0; timeout_clr_i = 1'b0;
    #3;
    check_eq("rst_grant", 32'(grant_o), 32'd0);
    check_eq("rst_timeout", 32'(timeout_o), 32'd0);
    check_eq("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    apply_reset();

    // Single m0 read, slave acks one cycle after the strobe.
    drive(0, 1, 1, 0, 4'hf, 32'h0000_0010, 32'h0);
    step();
    check_eq("t1_grant", 32'(grant_o), 32'd1);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'h4669626f;
    step();
    check_eq("t1_dat", obs_dat0, 32'h4669626f);
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0); s_ack_i = 1'b0;
    step(); step();

    // Simultaneous requests straight after reset, then alternation.
    apply_reset();
    drive(0, 1, 1, 0, 4'hf, 32'h100, 32'h0);
    drive(1, 1, 1, 1, 4'h3, 32'h200, 32'haaaa_5555);
    step();
    check_eq("t2_first", 32'(grant_o), 32'd1);
    s_ack_i = 1'b1; step();
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0); s_ack_i = 1'b0;
    step();
    check_eq("t2_idle", 32'(grant_o), 32'd0);
    step();
    check_eq("t2_second", 32'(grant_o), 32'd2);
    s_ack_i = 1'b1; step();
    drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0); s_ack_i = 1'b0;
    step();
    drive(0, 1, 1, 0, 4'hf, 32'h104, 32'h0);
    drive(1, 1, 1, 0, 4'hf, 32'h204, 32'h0);
    step();
    check_eq("t2_alt", 32'(grant_o), 32'd1);
    s_ack_i = 1'b1; step();
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0); s_ack_i = 1'b0;
    step(); step();
    s_ack_i = 1'b1; step();
    drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0); s_ack_i = 1'b0;
    step(); step();

    // Locked burst of three writes from m1 while m0 keeps requesting.
    drive(1, 1, 1, 1, 4'hf, 32'h300, 32'h1);
    step();
    check_eq("t3_grant", 32'(grant_o), 32'd2);
    drive(0, 1, 1, 0, 4'hf, 32'h400, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, 1, 1, 4'hf, 32'h300 + 32'(4 * k), 32'(k));
      step();
      s_ack_i = 1'b1; step();
      s_ack_i = 1'b0;
      drive(1, 1, 0, 0, 4'h0, 32'h0, 32'h0);
      step();
      check_eq("t3_held", 32'(grant_o), 32'd2);
    end
    drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    check_eq("t3_release", 32'(grant_o), 32'd0);
    step();
    check_eq("t3_m0", 32'(grant_o), 32'd1);
    s_ack_i = 1'b1; step();
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0); s_ack_i = 1'b0;
    step(); step();

    // Hung slave: timeout after exactly TO stall cycles; clear held high the whole time.
    drive(0, 1, 1, 0, 4'hf, 32'h500, 32'h0);
    timeout_clr_i = 1'b1;
    step();
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (e_ack0) break;
      stalls++;
    end
    check_eq("t4_stalls", 32'(stalls), 32'(TO));
    check_eq("t4_stb", 32'(obs_stb), 32'd0);
    check_eq("t4_dat", obs_dat0, TOD);
    timeout_clr_i = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    check_eq("t4_sticky", 32'(timeout_o), 32'd1);
    step(); step();
    timeout_clr_i = 1'b1; step();
    timeout_clr_i = 1'b0;
    check_eq("t4_clr", 32'(timeout_o), 32'd0);

    // Slave acks exactly when the counter reaches TO.
    drive(0, 1, 1, 0, 4'hf, 32'h600, 32'h0);
    step();
    repeat (TO) step();
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    step();
    check_eq("t5_dat", obs_dat0, 32'h1234_5678);
    check_eq("t5_noto", 32'(timeout_o), 32'd0);
    s_ack_i = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step(); step();

    // Asynchronous reset in the middle of an m1 burst.
    drive(1, 1, 1, 1, 4'hf, 32'h700, 32'h77);
    step();
    check_eq("t6_grant", 32'(grant_o), 32'd2);
    s_ack_i = 1'b1; s_dat_i = 32'h5a5a_5a5a;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_grant_rst", 32'(grant_o), 32'd0);
    check_eq("t6_s_cyc_rst", 32'(s_cyc_o), 32'd0);
    check_eq("t6_s_stb_rst", 32'(s_stb_o), 32'd0);
    check_eq("t6_s_adr_rst", s_adr_o, 32'd0);
    check_eq("t6_m1_ack_rst", 32'(m1_ack_o), 32'd0);
    check_eq("t6_m1_dat_rst", m1_dat_o, 32'd0);
    apply_reset();
    drive(0, 1, 1, 0, 4'hf, 32'h800, 32'h0);
    drive(1, 1, 1, 0, 4'hf, 32'h900, 32'h0);
    step();
    check_eq("t6_after", 32'(grant_o), 32'd1);
    apply_reset();

    // Randomized traffic with occasional hung-slave phases.
    hung = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) hung = ($urandom_range(2) == 0);
      rand_master(0, e_ack0);
      rand_master(1, e_ack1);
      s_ack_i       = !hung && ($urandom_range(2) == 0);
      s_dat_i       = $urandom;
      timeout_clr_i = ($urandom_range(49) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter placed in front of the Fibonacci control/status register slave.
- Lets the management SoC (master 0) and an on-chip test sequencer (master 1) share that slave.
- Round-robin grant, with the grant held for the whole cycle (cyc) of the granted master.
- A per-access stall timeout terminates accesses to a hung slave with a known data pattern and a sticky status flag.

Parameters:
- TIMEOUT, 16: cycles a strobed access may wait for s_ack_i before the arbiter terminates it; range 2..255.
- TIMEOUT_DATA, 32'hdead_beef: read data returned on a timed-out access.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe, write enable.
- m0_sel_i  in  4  master 0 byte select.
- m0_adr_i  in  32  master 0 address.
- m0_dat_i  in  32  master 0 write data.
- m0_ack_o  out  1  master 0 acknowledge.
- m0_dat_o  out  32  master 0 read data.
- m1_* (all of the above)  same directions and widths  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave.
- s_sel_o  out  4  to slave.
- s_adr_o  out  32  to slave.
- s_dat_o  out  32  to slave.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  32  slave read data.
- grant_o  out  2  one-hot current grant; 2'b00 when idle.
- timeout_o  out  1  sticky: at least one access timed out.
- timeout_clr_i  in  1  synchronous clear of timeout_o.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is asynchronous, active-low, on wb_rst_n_i.
- Reset values: state=IDLE, grant=00, last=1 (master 0 wins the first tie), counter=0, timeout_o=0. All s_* outputs and m*_ack_o/m*_dat_o are 0 while reset is asserted. Reset is also applied the same way mid-transaction; no ack is issued.
- Request: reqN = mN_cyc_i & mN_stb_i.
- State IDLE:
  - Only req0 -> grant=01.
  - Only req1 -> grant=10.
  - Both -> grant to the master other than last.
  - None -> stay in IDLE.
  - The grant register updates on the clock edge, so the first slave strobe appears the cycle after the request is seen (1-cycle arbitration latency).
- State BUSY (grant != 00):
  - s_cyc/s_stb/s_we/s_sel/s_adr/s_dat are a combinational mux of the granted master's inputs.
  - The granted master gets ack = s_ack_i and dat = s_dat_i, combinationally.
  - The ungranted master gets ack=0 and dat=0, and its request is held off.
  - Granted master drops cyc (sampled at edge) -> state=IDLE, grant=00, last=granted index.
  - Minimum one IDLE cycle between grants; no same-edge re-grant.
  - A master that keeps cyc high across several stb pulses keeps the bus (locked burst).
- Timeout counter (8 bits):
  - Cleared in IDLE, on any cycle with s_ack_i=1, and on any cycle with s_stb_o=0.
  - Otherwise increments each BUSY cycle with s_stb_o=1 and s_ack_i=0.
  - When counter==TIMEOUT and s_ack_i=0, in that cycle (combinational):
    - granted master sees ack=1 and dat=TIMEOUT_DATA;
    - s_stb_o is forced to 0;
    - timeout_o sets at the edge and the counter clears.
  - s_ack_i=1 in the same cycle as counter==TIMEOUT -> a normal ack; no timeout.
- timeout_clr_i:
  - Clears timeout_o at the edge.
  - Same-cycle timeout event and clear -> set wins (timeout_o=1).
- Writes and reads are passed through untouched; the arbiter does no address decoding.
- grant_o is always one-hot or zero; 2'b11 is never produced.

Test Plan:
- Reset release, m0 read with the slave acking 1 cycle after stb:
  - grant_o=01 one cycle after req0;
  - m0_ack_o equals s_ack_i;
  - m0_dat_o=s_dat_i (e.g. 32'h4669626f);
  - m1_ack_o stays 0.
- req0 and req1 asserted in the same cycle straight after reset:
  - master 0 is granted first;
  - after m0 drops cyc: one IDLE cycle, then grant_o=10;
  - then a second simultaneous request -> master 0 again (alternation).
- Locked burst: m1 issues 3 writes (32'h1, 32'h2, 32'h3) under one cyc while m0 requests throughout -> m0 is not granted until m1_cyc_i falls.
- Slave never acks, TIMEOUT=16:
  - exactly 16 stall cycles;
  - then m0_ack_o=1 with m0_dat_o=32'hdeadbeef, s_stb_o=0 in that cycle;
  - timeout_o=1 afterwards;
  - timeout_clr_i pulse -> timeout_o=0.
- Slave acks exactly at counter==TIMEOUT -> slave data is returned and timeout_o stays 0.
- Assert wb_rst_n_i low mid-burst while grant_o=10:
  - all outputs 0 immediately (asynchronously);
  - after release, a simultaneous request grants master 0 first.
